// File: rtl/regfile_sb.sv
// regfile_sb -- integer register file for the RISC-V core.
//   NREGS x XLEN storage with two combinational read ports, two synchronous
//   write ports (A = ALU writeback, B = load return), optional same-cycle
//   write-to-read forwarding, optional hardwired-zero x0, and a per-register
//   busy scoreboard tracking outstanding loads.
//   After reset a clear sequencer zeroes one entry per cycle (NREGS cycles)
//   and then raises ready; until then reads return 0 and all write/issue
//   inputs are ignored.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   ready              clear sequence finished, ports live
//   a1/a2 -> rd1/rd2   read address / data, busy1/busy2 scoreboard view
//   we_a,a3_a,wd_a     write port A (wins on address collision)
//   we_b,a3_b,wd_b     write port B, also clears busy[a3_b]
//   issue_ld,a_ld      mark busy[a_ld] for a newly issued load
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            ready,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we_a,
  input  logic [AW-1:0]   a3_a,
  input  logic [XLEN-1:0] wd_a,
  input  logic            we_b,
  input  logic [AW-1:0]   a3_b,
  input  logic [XLEN-1:0] wd_b,
  input  logic            issue_ld,
  input  logic [AW-1:0]   a_ld
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);
  localparam int NRP = 2;

  typedef enum logic {INIT, RUN} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          cnt_q, cnt_d;
  logic [NREGS-1:0]       busy_q, busy_d;
  logic [XLEN-1:0]        regs_q [NREGS];
  logic [XLEN-1:0]        regs_d [NREGS];

  // Write qualifiers: x0 swallows writes and load issues when hardwired.
  logic wr_a, wr_b, set_ld;
  assign wr_a   = we_a && !(ZR && a3_a == '0);
  assign wr_b   = we_b && !(ZR && a3_b == '0);
  assign set_ld = issue_ld && !(ZR && a_ld == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    regs_d  = regs_q;
    case (state_q)
      INIT: begin
        regs_d[cnt_q] = '0;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == AW'(NREGS - 1)) state_d = RUN;
      end
      default: begin
        // B first so A overwrites on a same-address collision.
        if (wr_b) regs_d[a3_b] = wd_b;
        if (wr_a) regs_d[a3_a] = wd_a;
        // Clear before set: a new load to the same register stays busy.
        if (we_b)   busy_d[a3_b] = 1'b0;
        if (set_ld) busy_d[a_ld] = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Storage carries no reset; the INIT sweep zeroes it.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  assign ready = (state_q == RUN);

  // Read ports.
  logic [NRP-1:0][AW-1:0]   ra;
  logic [NRP-1:0][XLEN-1:0] rdv;
  logic [NRP-1:0]           bsv;

  assign ra[0] = a1;
  assign ra[1] = a2;

  always_comb begin
    for (int p = 0; p < NRP; p++) begin
      rdv[p] = regs_q[ra[p]];
      bsv[p] = busy_q[ra[p]];
      if (BP) begin
        // A is applied last so it takes priority over B.
        if (we_b && a3_b == ra[p]) begin
          rdv[p] = wd_b;
          bsv[p] = 1'b0;
        end
        if (we_a && a3_a == ra[p]) rdv[p] = wd_a;
      end
      if (state_q != RUN || (ZR && ra[p] == '0)) begin
        rdv[p] = '0;
        bsv[p] = 1'b0;
      end
    end
  end

  assign rd1   = rdv[0];
  assign rd2   = rdv[1];
  assign busy1 = bsv[0];
  assign busy2 = bsv[1];

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic ready, busy1, busy2;
  logic [AW-1:0] a1, a2, a3_a, a3_b, a_ld;
  logic [XLEN-1:0] rd1, rd2, wd_a, wd_b;
  logic we_a, we_b, issue_ld;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2),
    .we_a(we_a), .a3_a(a3_a), .wd_a(wd_a),
    .we_b(we_b), .a3_b(a3_b), .wd_b(wd_b),
    .issue_ld(issue_ld), .a_ld(a_ld));

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  // Reference model: architectural register values and busy flags.
  logic [XLEN-1:0] mreg [NREGS];
  bit mbusy [NREGS];
  bit mrdy;
  int icnt;

  task automatic idle();
    we_a = 0; we_b = 0; issue_ld = 0;
    a3_a = '0; a3_b = '0; a_ld = '0; wd_a = '0; wd_b = '0;
  endtask

  // Advance one clock edge and apply the architectural effect of the inputs.
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      if (!mrdy) begin
        icnt++;
        if (icnt == NREGS) mrdy = 1;
      end else begin
        if (we_b && a3_b != 0) mreg[a3_b] = wd_b;
        if (we_a && a3_a != 0) mreg[a3_a] = wd_a;
        if (we_b) mbusy[a3_b] = 0;
        if (issue_ld && a_ld != 0) mbusy[a_ld] = 1;
      end
    end
    #1;
  endtask

  task automatic model_reset();
    mrdy = 0; icnt = 0;
    for (int i = 0; i < NREGS; i++) begin mreg[i] = '0; mbusy[i] = 0; end
  endtask

  task automatic wait_init();
    for (int i = 0; i < 40 && !mrdy; i++) step();
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    if (!mrdy || a == 0) return '0;
    if (we_a && a3_a == a) return wd_a;
    if (we_b && a3_b == a) return wd_b;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (!mrdy || a == 0) return 1'b0;
    if (we_b && a3_b == a) return 1'b0;
    return mbusy[a];
  endfunction

  task automatic test_reset();
    int n;
    idle(); a1 = 5'd4; a2 = 5'd17;
    rst_n = 0; model_reset();
    #1;
    checks++; if (ready !== 1'b0) begin errs++; $display("FAIL reset_ready: got %b want 0", ready); end
    repeat (3) step();
    rst_n = 1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready === 1'b1) break;
      checks++; if (rd1 !== '0 || busy1 !== 1'b0) begin errs++; $display("FAIL init_read: rd1=%h busy1=%b want 0/0", rd1, busy1); end
      n++;
      step();
    end
    checks++; if (n != NREGS) begin errs++; $display("FAIL init_len: got %0d cycles want %0d", n, NREGS); end
    checks++; if (ready !== mrdy) begin errs++; $display("FAIL ready_after_init: got %b want %b", ready, mrdy); end
    for (int r = 0; r < NREGS; r += 4) begin
      a1 = AW'(r); a2 = AW'(r + 3);
      #1;
      checks++; if (rd1 !== '0 || rd2 !== '0) begin errs++; $display("FAIL zero_after_init r%0d: %h %h want 0", r, rd1, rd2); end
    end
  endtask

  task automatic test_bypass();
    idle(); we_a = 1; a3_a = 5; wd_a = 32'hDEADBEEF; a1 = 5;
    @(negedge clk);
    checks++; if (rd1 !== 32'hDEADBEEF) begin errs++; $display("FAIL bypass_a: got %h want deadbeef", rd1); end
    step(); idle(); a1 = 5; #1;
    checks++; if (rd1 !== 32'hDEADBEEF) begin errs++; $display("FAIL stored_a: got %h want deadbeef", rd1); end
  endtask

  task automatic test_dual_write();
    idle(); we_a = 1; we_b = 1; a3_a = 7; a3_b = 7; wd_a = 32'h11; wd_b = 32'h22; a2 = 7;
    @(negedge clk);
    checks++; if (rd2 !== 32'h11) begin errs++; $display("FAIL dual_bypass: got %h want 11", rd2); end
    step(); idle(); a2 = 7; #1;
    checks++; if (rd2 !== 32'h11) begin errs++; $display("FAIL dual_stored: got %h want 11", rd2); end
  endtask

  task automatic test_zero_reg();
    idle(); we_a = 1; a3_a = 0; wd_a = 32'hFFFF_FFFF; issue_ld = 1; a_ld = 0; a1 = 0; a2 = 0;
    @(negedge clk);
    checks++; if (rd1 !== '0) begin errs++; $display("FAIL x0_bypass: got %h want 0", rd1); end
    step(); idle(); a1 = 0; a2 = 0; #1;
    checks++; if (rd1 !== '0 || busy2 !== 1'b0) begin errs++; $display("FAIL x0_after: rd=%h busy=%b want 0/0", rd1, busy2); end
  endtask

  task automatic test_scoreboard();
    idle(); issue_ld = 1; a_ld = 9; a1 = 9;
    step(); idle(); a1 = 9; #1;
    checks++; if (busy1 !== 1'b1) begin errs++; $display("FAIL busy_set: got %b want 1", busy1); end
    we_b = 1; a3_b = 9; wd_b = 32'h55;
    @(negedge clk);
    checks++; if (busy1 !== 1'b0 || rd1 !== 32'h55) begin errs++; $display("FAIL busy_bypass: busy=%b rd=%h want 0/55", busy1, rd1); end
    step(); idle(); a1 = 9; #1;
    checks++; if (busy1 !== 1'b0 || rd1 !== 32'h55) begin errs++; $display("FAIL busy_clr: busy=%b rd=%h want 0/55", busy1, rd1); end
    issue_ld = 1; a_ld = 9; we_b = 1; a3_b = 9; wd_b = 32'h66;
    step(); idle(); a2 = 9; #1;
    checks++; if (busy2 !== 1'b1 || rd2 !== 32'h66) begin errs++; $display("FAIL set_wins: busy=%b rd=%h want 1/66", busy2, rd2); end
    we_b = 1; a3_b = 9; step(); idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      we_a = 1'($urandom); we_b = 1'($urandom); issue_ld = 1'($urandom);
      a3_a = AW'($urandom_range(0, 7)); a3_b = AW'($urandom_range(0, 7));
      a_ld = AW'($urandom_range(0, 7));
      a1 = AW'($urandom_range(0, 9)); a2 = AW'($urandom);
      wd_a = $urandom; wd_b = $urandom;
      @(negedge clk);
      checks++;
      if (rd1 !== exp_rd(a1) || rd2 !== exp_rd(a2) || busy1 !== exp_busy(a1) || busy2 !== exp_busy(a2) || ready !== mrdy) begin
        errs++;
        $display("FAIL rand[%0d]: rd1=%h/%h rd2=%h/%h b1=%b/%b b2=%b/%b rdy=%b/%b", i,
                 rd1, exp_rd(a1), rd2, exp_rd(a2), busy1, exp_busy(a1), busy2, exp_busy(a2), ready, mrdy);
      end
      step();
    end
    idle();
  endtask

  task automatic test_reset_mid_run();
    // Writes while clearing must be ignored.
    idle(); rst_n = 0; model_reset(); step(); step(); rst_n = 1;
    we_a = 1; a3_a = 3; wd_a = 32'hBAD0_0001; we_b = 1; a3_b = 4; wd_b = 32'hBAD0_0002;
    issue_ld = 1; a_ld = 3;
    wait_init(); idle(); a1 = 3; a2 = 4; #1;
    checks++; if (ready !== 1'b1) begin errs++; $display("FAIL init_ready: got %b want 1", ready); end
    checks++; if (rd1 !== '0 || rd2 !== '0 || busy1 !== 1'b0) begin errs++; $display("FAIL init_writes: rd1=%h rd2=%h busy=%b want 0", rd1, rd2, busy1); end
    we_a = 1; a3_a = 3; wd_a = 32'hA5; issue_ld = 1; a_ld = 6;
    step(); idle(); a1 = 3; a2 = 6; #1;
    checks++; if (rd1 !== 32'hA5 || busy2 !== 1'b1) begin errs++; $display("FAIL pre_reset: rd=%h busy=%b want a5/1", rd1, busy2); end
    @(negedge clk); rst_n = 0; model_reset(); #1;
    checks++; if (ready !== 1'b0 || busy2 !== 1'b0) begin errs++; $display("FAIL mid_reset: ready=%b busy=%b want 0/0", ready, busy2); end
    step(); step(); rst_n = 1;
    wait_init(); a1 = 3; a2 = 6; #1;
    checks++; if (ready !== 1'b1 || rd1 !== '0 || busy2 !== 1'b0) begin errs++; $display("FAIL post_reset: ready=%b rd=%h busy=%b want 1/0/0", ready, rd1, busy2); end
  endtask

  initial begin
    idle(); a1 = '0; a2 = '0;
    test_reset();
    test_bypass();
    test_dual_write();
    test_zero_reg();
    test_scoreboard();
    test_random();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
